// File: rtl/cacheline_adapter.sv
// Cacheline adapter: turns one full-line cache request into a BEATS-long
// memory burst, holding bmem_read/bmem_write for the whole line.
module cacheline_adapter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] dfp_addr,
   input  logic                  dfp_read,
   input  logic                  dfp_write,
   input  logic [LINE_WIDTH-1:0] dfp_wdata,
   output logic [LINE_WIDTH-1:0] dfp_rdata,
   output logic                  dfp_resp,
   output logic [ADDR_WIDTH-1:0] bmem_address,
   output logic                  bmem_read,
   output logic                  bmem_write,
   output logic [BEAT_WIDTH-1:0] bmem_wdata,
   input  logic [BEAT_WIDTH-1:0] bmem_rdata,
   input  logic                  bmem_resp
);

   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
      ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_t;

   state_t                state, state_n;
   logic [CW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wbuf;
   logic [LINE_WIDTH-1:0] rbuf;
   logic                  last_beat;

   assign last_beat = (cnt == CW'(BEATS - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state: read beats write, DONE always returns to IDLE
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (dfp_read)       state_n = READ;
            else if (dfp_write) state_n = WRITE;
         end
         READ, WRITE: begin
            if (bmem_resp && last_beat) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Request latch, beat counter and line buffers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         addr_q <= '0;
         wbuf   <= '0;
         rbuf   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (dfp_read || dfp_write) begin
                  addr_q <= dfp_addr & ~OFF_MASK;
                  cnt    <= '0;
               end
               if (!dfp_read && dfp_write) wbuf <= dfp_wdata;
            end
            READ: begin
               if (bmem_resp) begin
                  rbuf[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
                  cnt <= cnt + CW'(1);
               end
            end
            WRITE: begin
               if (bmem_resp) cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from registered state and buffers only
   always_comb begin
      bmem_read    = (state == READ);
      bmem_write   = (state == WRITE);
      bmem_address = '0;
      bmem_wdata   = '0;
      if (state == READ || state == WRITE) bmem_address = addr_q;
      if (state == WRITE) bmem_wdata = wbuf[cnt*BEAT_WIDTH +: BEAT_WIDTH];
      dfp_resp  = (state == DONE);
      dfp_rdata = rbuf;
   end

endmodule
